// File: rtl/wb_commit_trace_fifo.sv
// Commit trace FIFO: captures every register-file write from the WB stage with a cycle stamp
// and presents the entries first-word-fall-through on a valid/ready port. Never stalls the pipe.
module wb_commit_trace_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned STAMP_W   = 16,
  parameter bit          FILTER_R0 = 1'b1,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   RegWrite_in,
  input  logic [4:0]             WriteRegister_in,
  input  logic [31:0]            WriteData_in,
  input  logic                   trace_ready,
  input  logic                   clear_overflow,
  output logic                   trace_valid,
  output logic [STAMP_W-1:0]     trace_stamp,
  output logic [4:0]             trace_reg,
  output logic [31:0]            trace_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  output logic [31:0]            commit_count
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = STAMP_W + 5 + 32;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [EntryW-1:0]  mem_q [DEPTH];
  logic [EntryW-1:0]  mem_d [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [STAMP_W-1:0] stamp_q, stamp_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;
  logic [31:0]        commit_count_q, commit_count_d;

  logic              commit;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic [EntryW-1:0] head;

  assign commit = RegWrite_in && !(FILTER_R0 && (WriteRegister_in == 5'd0));
  assign full   = (count_q == FullCount);
  assign pop    = trace_valid && trace_ready;
  // A full FIFO still accepts a commit when the head leaves in the same cycle.
  assign push   = commit && (!full || pop);
  assign drop   = commit && full && !pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stamp_d  = stamp_q + STAMP_W'(1);

    if (push) begin
      mem_d[wr_ptr_q] = {stamp_q, WriteRegister_in, WriteData_in};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d     = overflow_q;
    drop_count_d   = drop_count_q;
    commit_count_d = commit_count_q;

    if (commit) begin
      commit_count_d = commit_count_q + 32'd1;
    end
    if (clear_overflow) begin
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end
    // Applied after the clear so a same-cycle drop is still recorded.
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_d != {DROP_W{1'b1}}) begin
        drop_count_d = drop_count_d + DROP_W'(1);
      end
    end
  end

  // Storage is reset too, so the head fields read zero before the first push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      stamp_q        <= '0;
      overflow_q     <= 1'b0;
      drop_count_q   <= '0;
      commit_count_q <= '0;
    end else begin
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      stamp_q        <= stamp_d;
      overflow_q     <= overflow_d;
      drop_count_q   <= drop_count_d;
      commit_count_q <= commit_count_d;
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign trace_valid  = (count_q != '0);
  assign trace_stamp  = head[EntryW-1 -: STAMP_W];
  assign trace_reg    = head[36:32];
  assign trace_data   = head[31:0];
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_wb_commit_trace_fifo.sv
// Directed bench for wb_commit_trace_fifo: inputs change and outputs are sampled on the falling edge.
module tb_wb_commit_trace_fifo;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rw;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        ready;
  logic        clr;
  logic        trace_valid;
  logic [15:0] trace_stamp;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [31:0] commit_count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  wb_commit_trace_fifo #(
    .DEPTH    (16),
    .STAMP_W  (16),
    .FILTER_R0(1'b1),
    .DROP_W   (8)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .RegWrite_in     (rw),
    .WriteRegister_in(wreg),
    .WriteData_in    (wdata),
    .trace_ready     (ready),
    .clear_overflow  (clr),
    .trace_valid     (trace_valid),
    .trace_stamp     (trace_stamp),
    .trace_reg       (trace_reg),
    .trace_data      (trace_data),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .drop_count      (drop_count),
    .commit_count    (commit_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One rising edge, then back to the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
  endtask

  task automatic commit(input logic [4:0] r, input logic [31:0] d);
    rw    = 1'b1;
    wreg  = r;
    wdata = d;
    step();
    rw    = 1'b0;
  endtask

  function automatic logic [63:0] ent(input int s, input int r, input logic [31:0] d);
    logic [15:0] s16;
    logic [4:0]  r5;
    s16 = 16'(s);
    r5  = 5'(r);
    return {11'd0, s16, r5, d};
  endfunction

  function automatic logic [63:0] head();
    return {11'd0, trace_stamp, trace_reg, trace_data};
  endfunction

  initial begin
    reset_n = 1'b0;
    rw      = 1'bx;
    wreg    = 5'd0;
    wdata   = 32'd0;
    ready   = 1'b1;
    clr     = 1'b0;

    // Reset state, with RegWrite_in undriven while reset is held.
    #12;
    check("rst_valid", 64'(trace_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_head", head(), 64'd0);
    check("rst_commits", 64'(commit_count), 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    rw = 1'b0;
    do_reset();

    // Idle 10 cycles with ready high; the next commit carries stamp 10.
    repeat (10) step();
    check("idle_valid", 64'(trace_valid), 64'd0);
    check("idle_count", 64'(fifo_count), 64'd0);
    check("idle_commits", 64'(commit_count), 64'd0);
    ready = 1'b0;
    commit(5'd5, 32'h0000_1234);
    check("stamp10_head", head(), ent(10, 5, 32'h1234));
    check("stamp10_valid", 64'(trace_valid), 64'd1);
    ready = 1'b1;
    step();
    check("stamp10_popped", 64'(trace_valid), 64'd0);

    // Two captured commits plus a filtered write to r0.
    do_reset();
    ready = 1'b0;
    repeat (3) step();
    commit(5'd8, 32'h5);
    commit(5'd9, 32'hA);
    commit(5'd0, 32'h1);
    check("r0_count", 64'(fifo_count), 64'd2);
    check("r0_commits", 64'(commit_count), 64'd2);
    check("r0_head0", head(), ent(3, 8, 32'h5));
    ready = 1'b1;
    step();
    check("r0_head1", head(), ent(4, 9, 32'hA));
    step();
    check("r0_empty", 64'(trace_valid), 64'd0);

    // Twenty commits into 16 entries with no consumer.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 20; i++) commit(5'(i + 1), 32'h100 + 32'(i));
    check("ovf_count", 64'(fifo_count), 64'd16);
    check("ovf_flag", {63'd0, overflow}, 64'd1);
    check("ovf_drops", 64'(drop_count), 64'd4);
    check("ovf_commits", 64'(commit_count), 64'd20);
    check("ovf_head", head(), ent(0, 1, 32'h100));

    // Full with commit and pop together: no drop, new entry goes last.
    ready = 1'b1;
    commit(5'd21, 32'h114);
    ready = 1'b0;
    check("fullpp_count", 64'(fifo_count), 64'd16);
    check("fullpp_drops", 64'(drop_count), 64'd4);
    check("fullpp_commits", 64'(commit_count), 64'd21);
    ready = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check($sformatf("drain_%0d", i), head(), ent(i, i + 1, 32'h100 + 32'(i)));
      step();
    end
    check("drain_last", head(), ent(20, 21, 32'h114));
    step();
    check("drain_empty", 64'(trace_valid), 64'd0);
    ready = 1'b0;

    // Clear alone, then clear coinciding with a drop.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_flag", {63'd0, overflow}, 64'd0);
    check("clr_drops", 64'(drop_count), 64'd0);
    for (int i = 0; i < 16; i++) commit(5'd7, 32'(i));
    check("refill_ovf", {63'd0, overflow}, 64'd0);
    check("refill_count", 64'(fifo_count), 64'd16);
    clr = 1'b1;
    commit(5'd7, 32'hFF);
    clr = 1'b0;
    check("clrdrop_flag", {63'd0, overflow}, 64'd1);
    check("clrdrop_drops", 64'(drop_count), 64'd1);
    rw = 1'b1;
    wreg = 5'd6;
    repeat (260) step();
    rw = 1'b0;
    check("sat_drops", 64'(drop_count), 64'd255);
    check("sat_commits", 64'(commit_count), 64'd298);

    // Reset while seven entries are held.
    do_reset();
    for (int i = 0; i < 7; i++) commit(5'd4, 32'(i));
    check("mid_count", 64'(fifo_count), 64'd7);
    reset_n = 1'b0;
    #1;
    check("async_valid", 64'(trace_valid), 64'd0);
    check("async_count", 64'(fifo_count), 64'd0);
    check("async_head", head(), 64'd0);
    check("async_commits", 64'(commit_count), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    cyc = 0;
    repeat (2) step();
    commit(5'd3, 32'hDEAD);
    check("post_count", 64'(fifo_count), 64'd1);
    check("post_head", head(), ent(2, 3, 32'hDEAD));
    ready = 1'b1;
    step();
    check("post_empty", 64'(trace_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_commit_trace_fifo.md
Name: wb_commit_trace_fifo

Overview:
- Sits directly downstream of the WB stage of the 5-stage pipeline.
- Taps the register-file write port (RegWrite, WriteRegister, WriteData) and captures every architectural register commit into a timestamped FIFO.
- A host or bench drains entries over a valid/ready interface, replacing the negedge register-file dump with per-commit trace records.
- Purely observational: it never back-pressures the pipeline.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- STAMP_W, 16, width of the free-running cycle stamp.
- FILTER_R0, 1, when 1, writes to register 0 are not captured.
- DROP_W, 8, width of the saturating dropped-commit counter.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- RegWrite_in  in  1  WB-stage register write enable.
- WriteRegister_in  in  5  WB-stage destination register.
- WriteData_in  in  32  WB-stage write data.
- trace_ready  in  1  consumer accepts the head entry this cycle.
- clear_overflow  in  1  synchronous clear of overflow and drop_count.
- trace_valid  out  1  head entry present.
- trace_stamp  out  STAMP_W  cycle stamp of the head entry.
- trace_reg  out  5  destination register of the head entry.
- trace_data  out  32  write data of the head entry.
- fifo_count  out  log2(DEPTH)+1  current occupancy.
- overflow  out  1  sticky; a commit was dropped.
- drop_count  out  DROP_W  number of dropped commits, saturating.
- commit_count  out  32  total commits captured or dropped; wraps.

Behaviour:
- Reset (async assert, sync release): read/write pointers = 0; fifo_count = 0; trace_valid = 0; trace_stamp, trace_reg and trace_data = 0; overflow = 0; drop_count = 0; commit_count = 0; stamp counter = 0.
- Stamp counter: increments by 1 every clock after reset and wraps modulo 2^STAMP_W. An entry records the counter value in the cycle its commit is sampled.
- Commit: RegWrite_in = 1 AND NOT (FILTER_R0 = 1 AND WriteRegister_in = 0).
  - Every commit increments commit_count by 1, whether it is captured or dropped.
- Pop: trace_valid AND trace_ready. Removes the head entry at the clock edge.
- Push: a commit while fifo_count < DEPTH, OR a commit while full with a pop in the same cycle.
  - Push writes {stamp, WriteRegister_in, WriteData_in} at the write pointer.
- Simultaneous push and pop: fifo_count unchanged, both pointers advance.
  - When the FIFO is empty, no pop is possible (trace_valid = 0), so a push in that cycle is stored and fifo_count becomes 1.
- Drop: a commit while full with no pop.
  - Entry discarded; overflow <= 1; drop_count += 1, saturating at 2^DROP_W-1.
- clear_overflow = 1: overflow <= 0 and drop_count <= 0.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_count = 1.
- Read side is first-word-fall-through.
  - trace_valid = (fifo_count != 0).
  - trace_stamp, trace_reg and trace_data reflect mem[rd_ptr] combinationally from storage and are stable while trace_valid = 1 and no pop occurs.
  - Write-to-valid latency is 1 cycle: an entry pushed at edge N is visible after edge N.
- The FIFO-empty contents of trace_stamp, trace_reg and trace_data are don't-care after reset, but must be 0 until the first push.
- trace_ready while trace_valid = 0 is ignored. Pointers wrap modulo DEPTH.
- Reset mid-operation: all contents discarded immediately; no partial entries survive.
- X on RegWrite_in during reset is ignored.

Test Plan:
- Reset then idle 10 cycles, trace_ready = 1 -> trace_valid = 0, fifo_count = 0, commit_count = 0, stamp advances to 10.
- Three commits: r8=0x00000005 at stamp 3, r9=0x0000000A at stamp 4, r0=0x1 at stamp 5, with FILTER_R0 = 1 -> two entries (3,8,0x5) and (4,9,0xA) drained in order; commit_count = 2.
- trace_ready = 0, 20 consecutive commits into DEPTH = 16 -> fifo_count = 16, overflow = 1, drop_count = 4, commit_count = 20; the 16 drained entries are the first 16 in order.
- FIFO full, commit and pop in the same cycle -> no drop, fifo_count stays 16, new entry appears last.
- clear_overflow pulsed alone, then again together with a drop -> first gives overflow = 0, drop_count = 0; second gives overflow = 1, drop_count = 1.
- reset_n asserted mid-stream with 7 entries held -> outputs return to reset values asynchronously; after release the first new commit is the sole entry.
